// File: rtl/ctrl_pkg.sv
// ctrl_pkg: state enum, instruction classes, opcode and alu_op constants shared by the controller and the ALU control decoder
package ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEM_ADR = 4'd2,
    MEM_RD  = 4'd3,
    MEM_WB  = 4'd4,
    MEM_WR  = 4'd5,
    R_EXEC  = 4'd6,
    R_WB    = 4'd7,
    I_EXEC  = 4'd8,
    I_WB    = 4'd9,
    BRANCH  = 4'd10,
    JUMP    = 4'd11
  } state_t;
  typedef enum logic [2:0] {
    CLS_R, CLS_LW, CLS_SW, CLS_I, CLS_BR, CLS_J, CLS_ILL
  } cls_t;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGT  = 6'b010000;
  localparam logic [5:0] OP_BGE  = 6'b010001;
  localparam logic [5:0] OP_BLT  = 6'b010010;
  localparam logic [5:0] OP_BLE  = 6'b010011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [3:0] ALU_FUNCT = 4'b0000;
  localparam logic [3:0] ALU_ADD   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_BEQ   = 4'b0100;
  localparam logic [3:0] ALU_BNE   = 4'b0101;
  localparam logic [3:0] ALU_BGT   = 4'b0110;
  localparam logic [3:0] ALU_BGE   = 4'b0111;
  localparam logic [3:0] ALU_BLT   = 4'b1000;
  localparam logic [3:0] ALU_BLE   = 4'b1001;
endpackage

// File: rtl/ctrl_opdecode.sv
// ctrl_opdecode: combinational opcode -> instruction class and alu_op (in: opcode[5:0]; out: cls, alu_op[3:0])
module ctrl_opdecode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output cls_t       cls,
  output logic [3:0] alu_op
);
  always_comb begin
    cls    = CLS_ILL;
    alu_op = ALU_ADD;
    case (opcode)
      OP_R:    begin cls = CLS_R;  alu_op = ALU_FUNCT; end
      OP_LW:   cls = CLS_LW;
      OP_SW:   cls = CLS_SW;
      OP_ADDI: cls = CLS_I;
      OP_ANDI: begin cls = CLS_I;  alu_op = ALU_AND; end
      OP_ORI:  begin cls = CLS_I;  alu_op = ALU_OR;  end
      OP_BEQ:  begin cls = CLS_BR; alu_op = ALU_BEQ; end
      OP_BNE:  begin cls = CLS_BR; alu_op = ALU_BNE; end
      OP_BGT:  begin cls = CLS_BR; alu_op = ALU_BGT; end
      OP_BGE:  begin cls = CLS_BR; alu_op = ALU_BGE; end
      OP_BLT:  begin cls = CLS_BR; alu_op = ALU_BLT; end
      OP_BLE:  begin cls = CLS_BR; alu_op = ALU_BLE; end
      OP_J:    cls = CLS_J;
      default: cls = CLS_ILL;
    endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle CPU control FSM (in: clk, reset_n, opcode, mem_ready; out: datapath controls, state, sticky illegal_op)
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_op,
  output logic [3:0] state,
  output logic       illegal_op
);
  state_t     state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       illegal_q, illegal_d;
  cls_t       cls;
  logic [3:0] dec_alu_op;
  logic       ready;
  assign ready      = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state      = state_q;
  assign illegal_op = illegal_q;
  ctrl_opdecode u_dec (
    .opcode (state_q == DECODE ? opcode : opcode_q),
    .cls    (cls),
    .alu_op (dec_alu_op)
  );
  assign opcode_d  = state_q == DECODE ? opcode : opcode_q;
  assign illegal_d = illegal_q | (state_q == DECODE && cls == CLS_ILL);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FETCH;
      opcode_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      illegal_q <= illegal_d;
    end
  end
  always_comb begin
    state_d       = FETCH;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    pc_source     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 4'b0000;
    case (state_q)
      FETCH: begin
        mem_read  = reset_n;
        ir_write  = reset_n & ready;
        pc_write  = reset_n & ready;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        state_d   = ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        state_d   = (cls == CLS_LW || cls == CLS_SW) ? MEM_ADR :
                    cls == CLS_R  ? R_EXEC :
                    cls == CLS_I  ? I_EXEC :
                    cls == CLS_BR ? BRANCH :
                    cls == CLS_J  ? JUMP : FETCH;
      end
      MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        state_d   = cls == CLS_SW ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        state_d  = ready ? MEM_WB : MEM_RD;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        state_d   = ready ? FETCH : MEM_WR;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = dec_alu_op;
        state_d   = I_WB;
      end
      I_WB: reg_write = 1'b1;
      BRANCH: begin
        pc_write_cond = 1'b1;
        alu_src_a     = 1'b1;
        pc_source     = 2'b01;
        alu_op        = dec_alu_op;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      default: state_d = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle controller FSM sequences and outputs
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg;
  logic       ir_write, reg_write, reg_dst, alu_src_a, illegal_op;
  logic [1:0] pc_source, alu_src_b;
  logic [3:0] alu_op, state;
  int tests = 0;
  int failed = 0;
  multicycle_controller dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
    .alu_src_a(alu_src_a), .pc_source(pc_source), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .state(state), .illegal_op(illegal_op)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic [5:0] op, input logic rdy);
    @(negedge clk);
    opcode    = op;
    mem_ready = rdy;
    #1;
  endtask
  always @(negedge clk) begin
    if (reset_n === 1'b1 && pc_write === 1'b1 && pc_write_cond === 1'b1) begin
      tests++; failed++;
      $error("FAIL pc_excl: observed both pc writes 1 expected at most one");
    end
    if (reset_n === 1'b1 && mem_read === 1'b1 && mem_write === 1'b1) begin
      tests++; failed++;
      $error("FAIL mem_excl: observed read and write 1 expected at most one");
    end
  end
  initial begin
    reset_n = 1'b0; opcode = 6'b0; mem_ready = 1'b1;
    #1;
    chk("rst_state", state, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_alu_src_b", alu_src_b, 1);
    chk("rst_alu_op", alu_op, 1);
    chk("rst_illegal", illegal_op, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    cyc(6'b000000, 1'b1);
    chk("r_c1_state", state, 0);
    chk("r_c1_pc_write", pc_write, 1);
    chk("r_c1_ir_write", ir_write, 1);
    chk("r_c1_mem_read", mem_read, 1);
    chk("r_c1_i_or_d", i_or_d, 0);
    cyc(6'b000000, 1'b1);
    chk("r_c2_state", state, 1);
    chk("r_c2_alu_src_b", alu_src_b, 3);
    chk("r_c2_alu_op", alu_op, 1);
    chk("r_c2_pc_write", pc_write, 0);
    cyc(6'b000000, 1'b1);
    chk("r_c3_state", state, 6);
    chk("r_c3_alu_op", alu_op, 0);
    chk("r_c3_alu_src_a", alu_src_a, 1);
    cyc(6'b000000, 1'b1);
    chk("r_c4_state", state, 7);
    chk("r_c4_reg_write", reg_write, 1);
    chk("r_c4_reg_dst", reg_dst, 1);
    chk("r_c4_mem_to_reg", mem_to_reg, 0);
    cyc(6'b100011, 1'b1);
    chk("lw_c1_state", state, 0);
    cyc(6'b100011, 1'b1);
    chk("lw_c2_state", state, 1);
    cyc(6'b100011, 1'b0);
    chk("lw_c3_state", state, 2);
    chk("lw_c3_alu_src_b", alu_src_b, 2);
    chk("lw_c3_alu_src_a", alu_src_a, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(6'b100011, i == 2);
      chk("lw_rd_state", state, 3);
      chk("lw_rd_mem_read", mem_read, 1);
      chk("lw_rd_i_or_d", i_or_d, 1);
      chk("lw_rd_reg_write", reg_write, 0);
    end
    cyc(6'b100011, 1'b1);
    chk("lw_c7_state", state, 4);
    chk("lw_c7_reg_write", reg_write, 1);
    chk("lw_c7_mem_to_reg", mem_to_reg, 1);
    chk("lw_c7_reg_dst", reg_dst, 0);
    chk("lw_c7_mem_read", mem_read, 0);
    cyc(6'b010011, 1'b1);
    chk("ble_c1_state", state, 0);
    cyc(6'b010011, 1'b1);
    chk("ble_c2_state", state, 1);
    cyc(6'b000000, 1'b1);
    chk("ble_c3_state", state, 10);
    chk("ble_c3_pwc", pc_write_cond, 1);
    chk("ble_c3_pc_source", pc_source, 1);
    chk("ble_c3_alu_op", alu_op, 9);
    chk("ble_c3_pc_write", pc_write, 0);
    cyc(6'b111111, 1'b1);
    chk("ill_c1_state", state, 0);
    chk("ill_c1_flag", illegal_op, 0);
    cyc(6'b111111, 1'b1);
    chk("ill_c2_state", state, 1);
    chk("ill_c2_reg_write", reg_write, 0);
    chk("ill_c2_mem_write", mem_write, 0);
    cyc(6'b001101, 1'b1);
    chk("ill_c3_state", state, 0);
    chk("ill_c3_flag", illegal_op, 1);
    cyc(6'b001101, 1'b1);
    chk("ori_c2_state", state, 1);
    cyc(6'b000000, 1'b1);
    chk("ori_c3_state", state, 8);
    chk("ori_c3_alu_op", alu_op, 3);
    chk("ori_c3_alu_src_b", alu_src_b, 2);
    cyc(6'b000000, 1'b1);
    chk("ori_c4_state", state, 9);
    chk("ori_c4_reg_write", reg_write, 1);
    chk("ori_c4_reg_dst", reg_dst, 0);
    cyc(6'b000010, 1'b0);
    chk("j_stall_state", state, 0);
    chk("j_stall_pc_write", pc_write, 0);
    chk("j_stall_ir_write", ir_write, 0);
    chk("j_stall_mem_read", mem_read, 1);
    cyc(6'b000010, 1'b1);
    chk("j_c1_state", state, 0);
    chk("j_c1_pc_write", pc_write, 1);
    cyc(6'b000010, 1'b1);
    chk("j_c2_state", state, 1);
    cyc(6'b000000, 1'b1);
    chk("j_c3_state", state, 11);
    chk("j_c3_pc_write", pc_write, 1);
    chk("j_c3_pc_source", pc_source, 2);
    chk("j_c3_illegal_sticky", illegal_op, 1);
    cyc(6'b101011, 1'b1);
    chk("sw_c1_state", state, 0);
    cyc(6'b101011, 1'b1);
    chk("sw_c2_state", state, 1);
    cyc(6'b101011, 1'b0);
    chk("sw_c3_state", state, 2);
    cyc(6'b101011, 1'b0);
    chk("sw_c4_state", state, 5);
    chk("sw_c4_mem_write", mem_write, 1);
    chk("sw_c4_i_or_d", i_or_d, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("swrst_mem_write", mem_write, 0);
    chk("swrst_state", state, 0);
    chk("swrst_illegal", illegal_op, 0);
    chk("swrst_mem_read", mem_read, 0);
    @(posedge clk); #2 reset_n = 1'b1;
    cyc(6'b000000, 1'b1);
    chk("post_c1_state", state, 0);
    chk("post_c1_pc_write", pc_write, 1);
    chk("post_c1_mem_read", mem_read, 1);
    cyc(6'b000000, 1'b1);
    chk("post_c2_state", state, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT_EN, default 1, meaning: 1 = memory states stall on mem_ready; 0 = mem_ready is ignored and treated as 1.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port opcode, input, 6, instruction bits [31:26] from the instruction register.
REQ-005 SHALL have port mem_ready, input, 1, memory access completes in the cycle it is high.
REQ-006 SHALL have Moore outputs pc_write, pc_write_cond, i_or_d, mem_read, mem_write, mem_to_reg, ir_write, reg_write, reg_dst and alu_src_a, each 1 bit.
REQ-007 SHALL have Moore outputs pc_source (2), alu_src_b (2) and alu_op (4); alu_op drives the existing ALU control decoder.
REQ-008 SHALL have outputs state (4), the current state for debug, and illegal_op (1), a sticky flag.

Function
REQ-009 SHALL implement states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH and JUMP.
REQ-010 SHALL use opcodes R=000000, LW=100011, SW=101011, ADDI=001000, ANDI=001100, ORI=001101, BEQ=000100, BNE=000101, BGT=010000, BGE=010001, BLT=010010, BLE=010011 and J=000010.
REQ-011 FETCH SHALL assert mem_read, ir_write and pc_write, with i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=0001 and pc_source=00; it SHALL advance to DECODE only when mem_ready=1, otherwise hold with all writes deasserted.
REQ-012 DECODE SHALL drive alu_src_a=0, alu_src_b=11 and alu_op=0001, and SHALL branch on opcode: LW/SW to MEM_ADR, R to R_EXEC, ADDI/ANDI/ORI to I_EXEC, branches to BRANCH, J to JUMP, and any other opcode to FETCH with illegal_op set.
REQ-013 MEM_ADR SHALL drive alu_src_a=1, alu_src_b=10 and alu_op=0001, then go to MEM_RD for LW or MEM_WR for SW.
REQ-014 MEM_RD SHALL assert mem_read with i_or_d=1 and hold until mem_ready, then go to MEM_WB; MEM_WB SHALL assert reg_write with mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-015 MEM_WR SHALL assert mem_write with i_or_d=1 and hold until mem_ready, then go to FETCH.
REQ-016 R_EXEC SHALL drive alu_src_a=1, alu_src_b=00 and alu_op=0000; R_WB SHALL assert reg_write with reg_dst=1 and mem_to_reg=0, then go to FETCH.
REQ-017 I_EXEC SHALL drive alu_src_a=1 and alu_src_b=10, with alu_op 0001 for ADDI, 0010 for ANDI and 0011 for ORI; I_WB SHALL assert reg_write with reg_dst=0 and mem_to_reg=0, then go to FETCH.
REQ-018 I_EXEC and I_WB SHALL use the opcode held in an internal register captured in DECODE; the same opcode register SHALL select MEM_RD versus MEM_WR and the BRANCH alu_op.
REQ-019 BRANCH SHALL assert pc_write_cond with alu_src_a=1, alu_src_b=00, pc_source=01 and alu_op 0100/0101/0110/0111/1000/1001 for BEQ/BNE/BGT/BGE/BLT/BLE, then go to FETCH.
REQ-020 JUMP SHALL assert pc_write with pc_source=10, then go to FETCH.
REQ-021 Every output not named for a state SHALL be 0 in that state.
REQ-022 Instruction latency SHALL be, with zero wait: LW 5 cycles; SW, R and I-type 4; branch and J 3; each cycle of mem_ready=0 in FETCH, MEM_RD or MEM_WR SHALL add exactly one cycle.
REQ-023 pc_write and pc_write_cond SHALL never both be 1, and mem_read and mem_write SHALL never both be 1.
REQ-024 illegal_op SHALL stay set until reset; an illegal opcode SHALL NOT cause any register, memory or PC write beyond the FETCH of that instruction.
REQ-025 Any unencoded state value SHALL transition to FETCH on the next edge.

Reset
REQ-026 While reset_n=0, the block SHALL force state to FETCH, the opcode register and illegal_op to 0, and the outputs to FETCH values with pc_write, ir_write and mem_read gated to 0.
REQ-027 Assertion of reset_n SHALL take effect without a clock edge, including mid-instruction or mid-wait; after deassertion, the first active edge SHALL evaluate FETCH.

Structure
REQ-028 Package ctrl_pkg SHALL hold the state enum, opcode constants and alu_op constants 0000–1001, shared with the ALU control decoder.
REQ-029 A combinational sub-module ctrl_opdecode SHALL map opcode to instruction class and alu_op; the FSM and output logic SHALL reside in multicycle_controller.

Verification
REQ-030 R-type (000000), mem_ready=1 -> states FETCH, DECODE, R_EXEC, R_WB; reg_write=1 and reg_dst=1 in cycle 4; alu_op=0000 in cycle 3.
REQ-031 LW with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total; mem_read held 3 cycles with i_or_d=1; reg_write only in MEM_WB.
REQ-032 BLE (010011) -> 3 cycles; pc_write_cond=1, pc_source=01 and alu_op=1001 in cycle 3; pc_write=0.
REQ-033 Opcode 111111 -> DECODE then FETCH; illegal_op=1 and stays 1; no reg_write or mem_write.
REQ-034 reset_n pulled low during the MEM_WR wait -> mem_write drops immediately and state reads FETCH; after release, a normal fetch follows.
REQ-035 ORI then J back to back -> alu_op=0011 in I_EXEC, then pc_write=1 with pc_source=10 in JUMP; totals 4+3 cycles.
